// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI master controller: command encodings,
// controller state encoding, payload/frame widths and counter sizing.
package spi_pkg;

    localparam int ADDR_SIZE = 8;
    localparam int FRAME_W   = ADDR_SIZE + 2;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TURN,
        RECV,
        GAP
    } master_state_e;

    // Width needed to count 0 .. (longest phase - 1).
    function automatic int cnt_width(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Request port of the SPI master: host presents {cmd, data} with valid/ready.
interface spi_master_ctrl_if;
    import spi_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_cmd;
    logic [ADDR_SIZE-1:0] req_data;

    modport master (output req_valid, req_cmd, req_data, input req_ready);
    modport slave  (input req_valid, req_cmd, req_data, output req_ready);

endinterface

// File: rtl/spi_master_shifter.sv
// Datapath of the SPI master: parallel-load TX frame register shifted out
// MSB first, and an RX register assembling the returned byte MSB first.
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [FRAME_W-1:0]   frame_i,
    input  logic                 tx_shift_i,
    input  logic                 rx_shift_i,
    input  logic                 miso_i,
    output logic                 tx_msb_o,
    output logic [ADDR_SIZE-1:0] rx_next_o
);

    logic [FRAME_W-1:0]   tx_q;
    logic [ADDR_SIZE-1:0] rx_q;

    assign tx_msb_o  = tx_q[FRAME_W-1];
    assign rx_next_o = {rx_q[ADDR_SIZE-2:0], miso_i};

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            if (load_i) begin
                tx_q <= frame_i;
            end else if (tx_shift_i) begin
                tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
            end
            if (rx_shift_i) begin
                rx_q <= rx_next_o;
            end
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: serialises {cmd, data} frames onto MOSI/SS_n at one
// bit per clk and, for read-data commands, captures the byte returned on MISO.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int LEAD_CYCLES = 2,
    parameter int TURN_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_master_ctrl_if.slave     req,
    output logic                 MOSI,
    output logic                 SS_n,
    input  logic                 MISO,
    output logic [ADDR_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 done,
    output logic                 busy
);

    localparam int CNT_W = cnt_width(FRAME_W, ADDR_SIZE, LEAD_CYCLES, TURN_CYCLES, GAP_CYCLES);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LEAD_LAST  = cnt_t'(LEAD_CYCLES - 1);
    localparam cnt_t SHIFT_LAST = cnt_t'(FRAME_W - 1);
    localparam cnt_t TURN_LAST  = cnt_t'(TURN_CYCLES - 1);
    localparam cnt_t RECV_LAST  = cnt_t'(ADDR_SIZE - 1);
    localparam cnt_t GAP_LAST   = cnt_t'(GAP_CYCLES - 1);

    master_state_e        state_q, state_d;
    cnt_t                 cnt_q, cnt_d;
    cmd_e                 cmd_q, cmd_d;
    logic                 mosi_q, mosi_d;
    logic                 ss_n_q, ss_n_d;
    logic [ADDR_SIZE-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 accept;
    logic                 load;
    logic                 tx_shift;
    logic                 rx_shift;
    logic                 tx_msb;
    logic [ADDR_SIZE-1:0] rx_next;

    spi_master_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .frame_i    ({req.req_cmd, req.req_data}),
        .tx_shift_i (tx_shift),
        .rx_shift_i (rx_shift),
        .miso_i     (MISO),
        .tx_msb_o   (tx_msb),
        .rx_next_o  (rx_next)
    );

    assign req.req_ready = (state_q == IDLE);
    assign accept        = req.req_valid && (state_q == IDLE);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        load    = 1'b0;
        cnt_d   = cnt_q + cnt_t'(1);

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LEAD;
                    cmd_d   = cmd_e'(req.req_cmd);
                    load    = 1'b1;
                end
            end
            LEAD:  if (cnt_q == LEAD_LAST)  state_d = SHIFT;
            SHIFT: if (cnt_q == SHIFT_LAST) state_d = (cmd_q == CMD_RD_DATA) ? TURN : GAP;
            TURN:  if (cnt_q == TURN_LAST)  state_d = RECV;
            RECV:  if (cnt_q == RECV_LAST)  state_d = GAP;
            GAP:   if (cnt_q == GAP_LAST)   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Counters restart on every state entry and idle at zero.
        if (state_d != state_q || state_d == IDLE) begin
            cnt_d = '0;
        end

        // Outputs are registered, so they are derived from the next state.
        tx_shift = (state_d == SHIFT);
        rx_shift = (state_q == RECV);
        ss_n_d   = (state_d == IDLE) || (state_d == GAP);

        unique case (state_d)
            LEAD:    mosi_d = (state_q == IDLE) ? req.req_cmd[1] : tx_msb;
            SHIFT:   mosi_d = tx_msb;
            default: mosi_d = 1'b0;
        endcase

        rd_valid_d = (state_q == RECV) && (state_d == GAP);
        rd_data_d  = rd_valid_d ? rx_next : rd_data_q;
        done_d     = (state_d == GAP) && (cnt_d == GAP_LAST);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cmd_q      <= CMD_WR_ADDR;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign MOSI     = mosi_q;
    assign SS_n     = ss_n_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl: frame shapes on MOSI/SS_n,
// read-data capture, mid-frame reset and back-to-back request timing.
module tb_spi_master_ctrl;

    logic       clk;
    logic       rst;
    logic       MOSI;
    logic       SS_n;
    logic       MISO;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic       busy;

    int tests;
    int fails;

    // Per-frame observations
    int          f_low;
    logic [31:0] f_bits;
    int          f_ndone;
    int          f_done_k;
    int          f_nrdv;
    logic        f_tmo;

    // Mid-frame reset / back-to-back bookkeeping
    int          done_seen;
    logic        ss_mid;
    int          acc;
    logic        prev_busy;
    int          run;
    int          runs;
    int          run1;
    int          run2;
    int          hi_between;
    int          nd;
    int          d0;
    int          d1;
    logic [31:0] bits2;

    spi_master_ctrl_if bus ();

    spi_master_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .req      (bus),
        .MOSI     (MOSI),
        .SS_n     (SS_n),
        .MISO     (MISO),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge. Issues one request, then samples every negedge until
    // the controller is ready again, playing the slave's MISO byte on read-data.
    task automatic do_frame(input logic [1:0] cmd, input logic [7:0] data, input logic [7:0] mbyte);
        f_low    = 0;
        f_bits   = '0;
        f_ndone  = 0;
        f_done_k = 0;
        f_nrdv   = 0;
        f_tmo    = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_data  = data;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (SS_n === 1'b0) begin
                f_low++;
                f_bits = {f_bits[30:0], MOSI};
                MISO = (f_low >= 15 && f_low <= 22) ? mbyte[22-f_low] : 1'b0;
            end else begin
                MISO = 1'b0;
            end
            if (done === 1'b1) begin
                f_ndone++;
                f_done_k = k;
            end
            if (rd_valid === 1'b1) f_nrdv++;
            if (bus.req_ready === 1'b1 && k > 1) begin
                f_tmo = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        MISO = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_cmd   = 2'b00;
        bus.req_data  = 8'h00;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ss_n", SS_n, 1);
        check("reset_mosi", MOSI, 0);
        check("reset_ready", bus.req_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 8'h00);

        // Write address 0xEA: 0,0 lead then 00_11101010
        do_frame(2'b00, 8'hEA, 8'h00);
        check("wra_timeout", f_tmo, 0);
        check("wra_ss_low", f_low, 12);
        check("wra_mosi", f_bits, 32'h0EA);
        check("wra_done_cnt", f_ndone, 1);
        check("wra_done_cycle", f_done_k, 13);
        check("wra_rd_valid", f_nrdv, 0);

        // Write data 0x6B: 0,0 lead then 01_01101011
        do_frame(2'b01, 8'h6B, 8'h00);
        check("wrd_timeout", f_tmo, 0);
        check("wrd_ss_low", f_low, 12);
        check("wrd_mosi", f_bits, 32'h16B);
        check("wrd_done_cnt", f_ndone, 1);

        // Read address 0xEA: 1,1 lead then 10_11101010
        do_frame(2'b10, 8'hEA, 8'h00);
        check("rda_ss_low", f_low, 12);
        check("rda_mosi", f_bits, 32'hEEA);
        check("rda_rd_valid", f_nrdv, 0);

        // Read data, slave returns 0x6B
        do_frame(2'b11, 8'h00, 8'h6B);
        check("rdd_timeout", f_tmo, 0);
        check("rdd_ss_low", f_low, 22);
        check("rdd_mosi", f_bits, 32'h3C0000);
        check("rdd_done_cnt", f_ndone, 1);
        check("rdd_done_cycle", f_done_k, 23);
        check("rdd_rd_valid_cnt", f_nrdv, 1);
        check("rdd_rd_data", rd_data, 8'h6B);

        // rd_data holds across a following write
        do_frame(2'b01, 8'hA5, 8'hFF);
        check("hold_rd_valid", f_nrdv, 0);
        check("hold_rd_data", rd_data, 8'h6B);

        // Reset asserted during the 5th SHIFT cycle of a write
        done_seen = 0;
        ss_mid = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_cmd   = 2'b01;
        bus.req_data  = 8'hC3;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (done === 1'b1) done_seen++;
            if (k == 7) begin
                ss_mid = SS_n;
                rst = 1'b1;
            end
        end
        check("midrst_ss_before", ss_mid, 0);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ss_n", SS_n, 1);
        check("midrst_mosi", MOSI, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", bus.req_ready, 1);
        check("midrst_rd_data", rd_data, 8'h00);
        @(negedge clk);
        if (done === 1'b1) done_seen++;
        check("midrst_no_done", done_seen, 0);
        check("midrst_ss_stays_high", SS_n, 1);

        do_frame(2'b00, 8'h3C, 8'h00);
        check("post_rst_ss_low", f_low, 12);
        check("post_rst_mosi", f_bits, 32'h03C);
        check("post_rst_done", f_ndone, 1);

        // Back-to-back with req_valid held: wr-addr 0x10 then wr-data 0x55
        acc = 0;
        prev_busy = 1'b0;
        run = 0;
        runs = 0;
        run1 = 0;
        run2 = 0;
        hi_between = 0;
        nd = 0;
        d0 = 0;
        d1 = 0;
        bits2 = '0;
        bus.req_valid = 1'b1;
        bus.req_cmd   = 2'b00;
        bus.req_data  = 8'h10;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy === 1'b1 && prev_busy === 1'b0) begin
                acc++;
                if (acc == 1) begin
                    bus.req_cmd  = 2'b01;
                    bus.req_data = 8'h55;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            prev_busy = busy;
            if (SS_n === 1'b0) begin
                run++;
                if (runs == 1) bits2 = {bits2[30:0], MOSI};
            end else begin
                if (run > 0) begin
                    runs++;
                    if (runs == 1) run1 = run;
                    else run2 = run;
                    run = 0;
                end
                if (runs == 1) hi_between++;
            end
            if (done === 1'b1) begin
                if (nd == 0) d0 = k;
                else d1 = k;
                nd++;
            end
        end
        check("b2b_accepts", acc, 2);
        check("b2b_frames", runs, 2);
        check("b2b_low1", run1, 12);
        check("b2b_low2", run2, 12);
        check("b2b_gap_min", (hi_between >= 1), 1);
        check("b2b_done_cnt", nd, 2);
        check("b2b_done_spacing", d1 - d0, 14);
        check("b2b_mosi2", bits2, 32'h155);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
